// File: rtl/mouse_cursor_tracker_pkg.sv
// ---------------------------------------------------------------------
// mouse_cursor_tracker_pkg : button indices and click FSM state encoding
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

package mouse_cursor_tracker_pkg;

   localparam int BTN_L = 0;
   localparam int BTN_R = 1;
   localparam int BTN_M = 2;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      FIRST_DOWN  = 3'd1,
      WAIT_SECOND = 3'd2,
      SECOND_DOWN = 3'd3,
      HELD        = 3'd4
   } click_state_e;

endpackage

`default_nettype wire

// File: rtl/mouse_cursor_tracker_if.sv
// ---------------------------------------------------------------------
// mouse_cursor_tracker_if : packet input and cursor/button output bundle
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

interface mouse_cursor_tracker_if #(
   parameter int POS_W   = 11,
   parameter int DELTA_W = 9
);
   logic               in_valid;
   logic [DELTA_W-1:0] in_dx;
   logic [DELTA_W-1:0] in_dy;
   logic [2:0]         in_buttons;
   logic               recenter;

   logic [POS_W-1:0]   cursor_x;
   logic [POS_W-1:0]   cursor_y;
   logic               out_valid;
   logic [2:0]         buttons;
   logic [2:0]         btn_press;
   logic [2:0]         btn_release;
   logic               double_click;
   logic               dragging;

   modport master (
      output in_valid, in_dx, in_dy, in_buttons, recenter,
      input  cursor_x, cursor_y, out_valid, buttons, btn_press, btn_release,
             double_click, dragging
   );

   modport slave (
      input  in_valid, in_dx, in_dy, in_buttons, recenter,
      output cursor_x, cursor_y, out_valid, buttons, btn_press, btn_release,
             double_click, dragging
   );
endinterface

`default_nettype wire

// File: rtl/mouse_click_fsm.sv
// ---------------------------------------------------------------------
// mouse_click_fsm : left-button double-click detector and drag flag
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module mouse_click_fsm
   import mouse_cursor_tracker_pkg::*;
#(
   parameter int DCLICK_CYCLES = 6750000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic l_press,
   input  logic l_release,
   input  logic moved,
   input  logic recenter,
   output logic double_click,
   output logic dragging
);

   localparam int CNT_W = (DCLICK_CYCLES > 1) ? $clog2(DCLICK_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DCLICK_CYCLES - 1);

   click_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic             double_click_q;
   logic             dragging_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= IDLE;
         cnt_q          <= '0;
         double_click_q <= 1'b0;
         dragging_q     <= 1'b0;
      end else begin
         double_click_q <= 1'b0;

         if (l_release || recenter) begin
            dragging_q <= 1'b0;
         end else if (moved) begin
            dragging_q <= 1'b1;
         end

         // The window runs from the first press; expiry outranks any event.
         case (state_q)
            IDLE: begin
               if (l_press) begin
                  state_q <= FIRST_DOWN;
                  cnt_q   <= '0;
               end
            end
            FIRST_DOWN: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= l_release ? IDLE : HELD;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (l_release) begin
                     state_q <= WAIT_SECOND;
                  end
               end
            end
            WAIT_SECOND: begin
               if (cnt_q == CNT_LAST) begin
                  state_q <= IDLE;
                  cnt_q   <= '0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
                  if (l_press) begin
                     double_click_q <= 1'b1;
                     state_q        <= SECOND_DOWN;
                  end
               end
            end
            SECOND_DOWN, HELD: begin
               if (l_release) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign double_click = double_click_q;
   assign dragging     = dragging_q;

endmodule

`default_nettype wire

// File: rtl/mouse_cursor_tracker.sv
// ---------------------------------------------------------------------
// mouse_cursor_tracker : accumulates PS/2 deltas into a clamped or
//                        wrapped screen position, with button events
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module mouse_cursor_tracker
   import mouse_cursor_tracker_pkg::*;
#(
   parameter int SCREEN_W      = 1024,
   parameter int SCREEN_H      = 768,
   parameter int POS_W         = 11,
   parameter int DELTA_W       = 9,
   parameter int GAIN_SHIFT    = 0,
   parameter int WRAP          = 0,
   parameter int INVERT_Y      = 1,
   parameter int INIT_X        = SCREEN_W / 2,
   parameter int INIT_Y        = SCREEN_H / 2,
   parameter int DCLICK_CYCLES = 6750000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   mouse_cursor_tracker_if.slave  bus
);

   // Two guard bits hold the signed sum of a position and a scaled delta.
   localparam int SUM_W = POS_W + 2;

   logic [1:0][POS_W-1:0] pos_q, pos_d, lim_pos;
   logic [1:0][SUM_W-1:0] delta;
   logic signed [SUM_W-1:0] dx_ext, dy_ext, dx_scaled, dy_scaled;
   logic [2:0] buttons_q, buttons_d;
   logic [2:0] press_q, press_d;
   logic [2:0] release_q, release_d;
   logic       out_valid_q, out_valid_d;
   logic       moved;

   always_comb begin
      dx_ext    = {{(SUM_W-DELTA_W){bus.in_dx[DELTA_W-1]}}, bus.in_dx};
      dy_ext    = {{(SUM_W-DELTA_W){bus.in_dy[DELTA_W-1]}}, bus.in_dy};
      dx_scaled = dx_ext <<< GAIN_SHIFT;
      dy_scaled = dy_ext <<< GAIN_SHIFT;
      delta[0]  = dx_scaled;
      delta[1]  = (INVERT_Y != 0) ? -dy_scaled : dy_scaled;
   end

   for (genvar a = 0; a < 2; a++) begin : g_axis
      localparam int SCREEN = (a == 0) ? SCREEN_W : SCREEN_H;
      localparam logic signed [SUM_W-1:0] SCREEN_S = SUM_W'(SCREEN);
      localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(SCREEN - 1);

      logic signed [SUM_W-1:0] sum;
      logic signed [SUM_W-1:0] fit;

      always_comb begin
         sum = signed'({2'b00, pos_q[a]}) + signed'(delta[a]);
         fit = sum;
         if (WRAP != 0) begin
            if (sum[SUM_W-1]) begin
               fit = sum + SCREEN_S;
            end else if (sum >= SCREEN_S) begin
               fit = sum - SCREEN_S;
            end
         end else begin
            if (sum[SUM_W-1]) begin
               fit = '0;
            end else if (sum > MAX_S) begin
               fit = MAX_S;
            end
         end
      end

      assign lim_pos[a] = fit[POS_W-1:0];
   end

   assign moved = bus.in_valid & buttons_q[BTN_L] & bus.in_buttons[BTN_L]
                & ((delta[0] != '0) | (delta[1] != '0));

   always_comb begin
      pos_d       = pos_q;
      buttons_d   = buttons_q;
      press_d     = '0;
      release_d   = '0;
      out_valid_d = 1'b0;
      if (bus.in_valid) begin
         pos_d       = lim_pos;
         buttons_d   = bus.in_buttons;
         press_d     = bus.in_buttons & ~buttons_q;
         release_d   = ~bus.in_buttons & buttons_q;
         out_valid_d = 1'b1;
      end
      // Recenter overrides the packet's movement but keeps its button edges.
      if (bus.recenter) begin
         pos_d[0]    = POS_W'(INIT_X);
         pos_d[1]    = POS_W'(INIT_Y);
         out_valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q[0]    <= POS_W'(INIT_X);
         pos_q[1]    <= POS_W'(INIT_Y);
         buttons_q   <= '0;
         press_q     <= '0;
         release_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         pos_q       <= pos_d;
         buttons_q   <= buttons_d;
         press_q     <= press_d;
         release_q   <= release_d;
         out_valid_q <= out_valid_d;
      end
   end

   mouse_click_fsm #(
      .DCLICK_CYCLES (DCLICK_CYCLES)
   ) u_click_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .l_press      (press_d[BTN_L]),
      .l_release    (release_d[BTN_L]),
      .moved        (moved),
      .recenter     (bus.recenter),
      .double_click (bus.double_click),
      .dragging     (bus.dragging)
   );

   assign bus.cursor_x    = pos_q[0];
   assign bus.cursor_y    = pos_q[1];
   assign bus.out_valid   = out_valid_q;
   assign bus.buttons     = buttons_q;
   assign bus.btn_press   = press_q;
   assign bus.btn_release = release_q;

endmodule

`default_nettype wire

// File: tb/tb_mouse_cursor_tracker.sv
// ---------------------------------------------------------------------
// tb_mouse_cursor_tracker : three parameterisations against a timeline model
// Rev 1.0
// ---------------------------------------------------------------------
`default_nettype none

module tb_mouse_cursor_tracker;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mouse_cursor_tracker_if #(.POS_W(11), .DELTA_W(9)) bus0 ();
   mouse_cursor_tracker_if #(.POS_W(11), .DELTA_W(9)) bus1 ();
   mouse_cursor_tracker_if #(.POS_W(11), .DELTA_W(9)) bus2 ();

   mouse_cursor_tracker #(.WRAP(0), .GAIN_SHIFT(0), .DCLICK_CYCLES(100))
      dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
   mouse_cursor_tracker #(.WRAP(1), .GAIN_SHIFT(0), .DCLICK_CYCLES(100))
      dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   mouse_cursor_tracker #(.WRAP(0), .GAIN_SHIFT(1), .DCLICK_CYCLES(100))
      dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

   int checks = 0;
   int errors = 0;

   // Reference model: positions per configuration, shared button/click view.
   int WR[3] = '{0, 1, 0};
   int GS[3] = '{0, 0, 1};
   int px[3];
   int py[3];
   logic [2:0] m_btn, e_press, e_rel;
   logic e_ov, e_dc, e_drag;
   bit ck_active, ck_released, ck_waitrel;
   int ck_t0;
   int tcyc = 0;
   logic [2:0] cur_btn = 3'b000;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic int fit(input int v, input int s, input int wrap);
      if (wrap != 0) return ((v % s) + s) % s;
      if (v < 0) return 0;
      if (v > s - 1) return s - 1;
      return v;
   endfunction

   task automatic model_reset();
      for (int c = 0; c < 3; c++) begin
         px[c] = 512;
         py[c] = 384;
      end
      m_btn = '0; e_press = '0; e_rel = '0;
      e_ov = 0; e_dc = 0; e_drag = 0;
      ck_active = 0; ck_released = 0; ck_waitrel = 0; ck_t0 = 0;
   endtask

   task automatic model_step(input bit v, input int dx, input int dy, input logic [2:0] b, input bit rc);
      bit moved, pr, rl;
      e_ov    = v | rc;
      e_press = v ? (b & ~m_btn) : 3'b000;
      e_rel   = v ? (~b & m_btn) : 3'b000;
      moved   = v && m_btn[0] && b[0] && (dx != 0 || dy != 0);
      for (int c = 0; c < 3; c++) begin
         if (v) begin
            px[c] = fit(px[c] + dx * (1 << GS[c]), 1024, WR[c]);
            py[c] = fit(py[c] - dy * (1 << GS[c]), 768, WR[c]);
         end
         if (rc) begin
            px[c] = 512;
            py[c] = 384;
         end
      end
      if (v) m_btn = b;
      if (e_rel[0] || rc) e_drag = 0;
      else if (moved) e_drag = 1;
      // Click timeline: a second press counts only within 100 cycles of the first.
      pr = e_press[0];
      rl = e_rel[0];
      e_dc = 0;
      if (ck_active) begin
         if (tcyc - ck_t0 >= 100) begin
            ck_active  = 0;
            ck_waitrel = !ck_released && !rl;
         end else if (!ck_released && rl) begin
            ck_released = 1;
         end else if (ck_released && pr) begin
            e_dc       = 1;
            ck_active  = 0;
            ck_waitrel = 1;
         end
      end else if (ck_waitrel) begin
         if (rl) ck_waitrel = 0;
      end else if (pr) begin
         ck_active   = 1;
         ck_t0       = tcyc;
         ck_released = 0;
      end
   endtask

   task automatic check_bus(input int c, input logic [10:0] x, input logic [10:0] y,
                            input logic ov, input logic [2:0] b, input logic [2:0] p,
                            input logic [2:0] r, input logic dc, input logic dr);
      check_eq($sformatf("cursor_x[%0d]", c), 32'(x), px[c]);
      check_eq($sformatf("cursor_y[%0d]", c), 32'(y), py[c]);
      check_eq($sformatf("out_valid[%0d]", c), 32'(ov), 32'(e_ov));
      check_eq($sformatf("buttons[%0d]", c), 32'(b), 32'(m_btn));
      check_eq($sformatf("btn_press[%0d]", c), 32'(p), 32'(e_press));
      check_eq($sformatf("btn_release[%0d]", c), 32'(r), 32'(e_rel));
      check_eq($sformatf("double_click[%0d]", c), 32'(dc), 32'(e_dc));
      check_eq($sformatf("dragging[%0d]", c), 32'(dr), 32'(e_drag));
   endtask

   task automatic compare_all();
      check_bus(0, bus0.cursor_x, bus0.cursor_y, bus0.out_valid, bus0.buttons,
                bus0.btn_press, bus0.btn_release, bus0.double_click, bus0.dragging);
      check_bus(1, bus1.cursor_x, bus1.cursor_y, bus1.out_valid, bus1.buttons,
                bus1.btn_press, bus1.btn_release, bus1.double_click, bus1.dragging);
      check_bus(2, bus2.cursor_x, bus2.cursor_y, bus2.out_valid, bus2.buttons,
                bus2.btn_press, bus2.btn_release, bus2.double_click, bus2.dragging);
   endtask

   task automatic drive(input bit v, input int dx, input int dy, input logic [2:0] b, input bit rc);
      bus0.in_valid = v; bus0.in_dx = 9'(dx); bus0.in_dy = 9'(dy); bus0.in_buttons = b; bus0.recenter = rc;
      bus1.in_valid = v; bus1.in_dx = 9'(dx); bus1.in_dy = 9'(dy); bus1.in_buttons = b; bus1.recenter = rc;
      bus2.in_valid = v; bus2.in_dx = 9'(dx); bus2.in_dy = 9'(dy); bus2.in_buttons = b; bus2.recenter = rc;
   endtask

   // Called at a falling edge: drive, model the next rising edge, check at the next falling edge.
   task automatic step(input bit v, input int dx, input int dy, input logic [2:0] b, input bit rc);
      drive(v, dx, dy, b, rc);
      model_step(v, dx, dy, b, rc);
      tcyc++;
      @(negedge clk);
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 3'b000, 0);
   endtask

   initial begin
      drive(0, 0, 0, 3'b000, 0);
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(negedge clk);
      compare_all();
      check_eq("rst_x", 32'(bus0.cursor_x), 512);
      check_eq("rst_y", 32'(bus0.cursor_y), 384);
      rst_n = 1'b1;

      // First packet, issued in the same cycle reset is released
      step(1, 100, 50, 3'b000, 0);
      check_eq("first_x", 32'(bus0.cursor_x), 612);
      check_eq("first_y", 32'(bus0.cursor_y), 334);
      check_eq("first_ov", 32'(bus0.out_valid), 1);
      idle(1);
      check_eq("ov_drop", 32'(bus0.out_valid), 0);

      // Clamp
      step(0, 0, 0, 3'b000, 1);
      step(1, 255, 255, 3'b000, 0);
      step(1, 233, 119, 3'b000, 0);
      check_eq("clamp_pre_x", 32'(bus0.cursor_x), 1000);
      check_eq("clamp_pre_y", 32'(bus0.cursor_y), 10);
      step(1, 100, 100, 3'b000, 0);
      check_eq("clamp_x", 32'(bus0.cursor_x), 1023);
      check_eq("clamp_y", 32'(bus0.cursor_y), 0);
      step(1, -255, 0, 3'b000, 0);
      check_eq("clamp_back_x", 32'(bus0.cursor_x), 768);

      // Wrap
      step(0, 0, 0, 3'b000, 1);
      step(1, 255, -255, 3'b000, 0);
      step(1, 233, -61, 3'b000, 0);
      step(1, 50, -100, 3'b000, 0);
      check_eq("wrap_x", 32'(bus1.cursor_x), 26);
      check_eq("wrap_y", 32'(bus1.cursor_y), 32);
      step(1, -30, 0, 3'b000, 0);
      check_eq("wrap_back_x", 32'(bus1.cursor_x), 1020);

      // Gain with back-to-back packets
      step(0, 0, 0, 3'b000, 1);
      check_eq("recenter_x", 32'(bus2.cursor_x), 512);
      for (int i = 1; i <= 3; i++) begin
         step(1, 10, 0, 3'b000, 0);
         check_eq("gain_x", 32'(bus2.cursor_x), 512 + 20 * i);
         check_eq("gain_ov", 32'(bus2.out_valid), 1);
      end

      // Double-click inside the window
      idle(110);
      step(1, 0, 0, 3'b001, 0);
      idle(19);
      step(1, 0, 0, 3'b000, 0);
      idle(39);
      step(1, 0, 0, 3'b001, 0);
      check_eq("dclick_hit", 32'(bus0.double_click), 1);
      check_eq("dclick_press", 32'(bus0.btn_press), 1);
      step(1, 0, 0, 3'b000, 0);
      idle(110);

      // Second press after the window has expired
      step(1, 0, 0, 3'b001, 0);
      idle(19);
      step(1, 0, 0, 3'b000, 0);
      idle(99);
      step(1, 0, 0, 3'b001, 0);
      check_eq("dclick_late", 32'(bus0.double_click), 0);
      step(1, 0, 0, 3'b000, 0);
      idle(110);

      // Drag, then recenter together with a packet
      step(1, 0, 0, 3'b001, 0);
      step(1, 5, 0, 3'b001, 0);
      check_eq("drag_set", 32'(bus0.dragging), 1);
      step(1, 40, 0, 3'b001, 1);
      check_eq("rc_x", 32'(bus0.cursor_x), 512);
      check_eq("rc_y", 32'(bus0.cursor_y), 384);
      check_eq("rc_drag", 32'(bus0.dragging), 0);
      check_eq("rc_ov", 32'(bus0.out_valid), 1);
      step(1, 0, 0, 3'b000, 0);
      cur_btn = 3'b000;

      // Randomised traffic
      for (int n = 0; n < 1500; n++) begin
         bit v, rc;
         int dx, dy;
         v  = ($urandom % 10) < 6;
         rc = ($urandom % 40) == 0;
         dx = (($urandom % 4) == 0) ? 0 : int'($urandom_range(0, 511)) - 256;
         dy = (($urandom % 4) == 0) ? 0 : int'($urandom_range(0, 511)) - 256;
         if (v && ($urandom % 5) == 0) cur_btn[0] = ~cur_btn[0];
         if (v && ($urandom % 8) == 0) cur_btn[1] = ~cur_btn[1];
         if (v && ($urandom % 8) == 0) cur_btn[2] = ~cur_btn[2];
         step(v, dx, dy, cur_btn, rc);
      end

      // Asynchronous reset in the middle of a cycle
      step(1, 37, -20, 3'b001, 0);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      check_eq("async_rst_x", 32'(bus0.cursor_x), 512);
      drive(0, 0, 0, 3'b000, 0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1, 100, 50, 3'b000, 0);
      check_eq("post_rst_x", 32'(bus0.cursor_x), 612);
      check_eq("post_rst_y", 32'(bus0.cursor_y), 334);
      drive(0, 0, 0, 3'b000, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
